// File: rtl/debounce_multi.sv
// -----------------------------------------------------------------------------
// debounce_multi
//   Multi-channel switch/comparator debouncer. Each channel has its own
//   input synchroniser and consecutive-stability counter. A new level is
//   accepted only after Teff = max(T,1) consecutive synchronised samples
//   disagree with the current filtered level. One-cycle rise/fall pulses
//   accompany every accepted transition.
//
// Ports
//   i_clk            system clock
//   i_reset          asynchronous, active-low reset
//   i_switch         [N_CH]   raw asynchronous inputs
//   i_debounce_time  [CNT_W]  required consecutive stable cycles T
//   i_enable         filter enable; low freezes filtered state
//   o_switch         [N_CH]   debounced level per channel
//   o_rise           [N_CH]   one-cycle pulse on 0->1 filtered transition
//   o_fall           [N_CH]   one-cycle pulse on 1->0 filtered transition
//   o_busy           [N_CH]   channel counter non-zero (transition pending)
// -----------------------------------------------------------------------------

// Single channel: synchroniser + stability counter + edge pulses.
module debounce_ch #(
    parameter int   CNT_W       = 16,
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_switch,
    input  logic [CNT_W-1:0] i_teff_m1,
    input  logic             i_enable,
    output logic             o_switch,
    output logic             o_rise,
    output logic             o_fall,
    output logic             o_busy
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   s;

    // Synchroniser runs regardless of i_enable so the filter sees a
    // settled sample the moment it is re-enabled.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_switch};
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Filter. The >= against the live threshold means a lowered T commits
    // on the very next mismatch cycle, and the counter is always cleared
    // no later than reaching Teff, so it cannot wrap.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_switch <= RESET_LEVEL;
            cnt      <= '0;
            o_rise   <= 1'b0;
            o_fall   <= 1'b0;
        end else begin
            o_rise <= 1'b0;
            o_fall <= 1'b0;
            if (!i_enable) begin
                cnt <= '0;
            end else if (s == o_switch) begin
                cnt <= '0;
            end else if (cnt >= i_teff_m1) begin
                o_switch <= s;
                cnt      <= '0;
                o_rise   <= s;
                o_fall   <= ~s;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign o_busy = (cnt != '0);
endmodule

module debounce_multi #(
    parameter int   N_CH        = 4,
    parameter int   CNT_W       = 16,
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [N_CH-1:0]  i_switch,
    input  logic [CNT_W-1:0] i_debounce_time,
    input  logic             i_enable,
    output logic [N_CH-1:0]  o_switch,
    output logic [N_CH-1:0]  o_rise,
    output logic [N_CH-1:0]  o_fall,
    output logic [N_CH-1:0]  o_busy
);
    // Shared compare value Teff-1; T = 0 is treated as T = 1.
    logic [CNT_W-1:0] teff_m1;

    assign teff_m1 = (i_debounce_time == '0) ? '0
                                             : i_debounce_time - CNT_W'(1);

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        debounce_ch #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES),
            .RESET_LEVEL (RESET_LEVEL)
        ) u_ch (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_switch  (i_switch[ch]),
            .i_teff_m1 (teff_m1),
            .i_enable  (i_enable),
            .o_switch  (o_switch[ch]),
            .o_rise    (o_rise[ch]),
            .o_fall    (o_fall[ch]),
            .o_busy    (o_busy[ch])
        );
    end
endmodule
